apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Two-requester arbiter and sequencer for a single APB master port in the PCLK domain. It accepts simple command requests from two internal masters, grants the bus round-robin, drives the APB SETUP/ACCESS protocol, and returns read data and error status to the winner. A PREADY timeout bounds stalls caused by a hung slave.

## Interface
Parameters:
- ADDR_W, 32, PADDR/request address width
- DATA_W, 32, PWDATA/PRDATA width; PSTRB width is DATA_W/8
- TIMEOUT, 16, max consecutive ACCESS cycles with PREADY low before abort; 0 disables

Ports (index i = requester 0/1; packed, requester 1 in upper slice):
- PCLK  in  1  sole clock
- PRESETn  in  1  asynchronous, active-low reset
- REQ_VALID  in  2  request pending; held with fields stable until REQ_DONE[i]
- REQ_WRITE  in  2  1 = write
- REQ_ADDR  in  2*ADDR_W  address
- REQ_WDATA  in  2*DATA_W  write data
- REQ_STRB  in  2*DATA_W/8  write strobes
- REQ_PROT  in  2*3  protection
- REQ_DONE  out  2  one-cycle completion pulse to the granted requester
- REQ_RDATA  out  DATA_W  read data, valid while REQ_DONE asserted
- REQ_ERR  out  1  error, valid while REQ_DONE asserted
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_W;  PWDATA  out  DATA_W;  PSTRB  out  DATA_W/8;  PROT  out  3
- PRDATA  in  DATA_W;  PREADY  in  1;  PSLVERR  in  1

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: if any REQ_VALID is high, pick a winner -> SETUP. Winner: the sole valid requester; if both are valid, the requester not recorded in last_grant. Update last_grant to the winner. last_grant resets to 1, so requester 0 wins the first tie.
- On grant, register REQ_* fields of the winner into PADDR/PWRITE/PWDATA/PSTRB/PROT. Later requester changes are ignored until DONE.
- Read requests drive PSTRB = 0 and PWDATA = 0.
- SETUP: PSEL=1, PENABLE=0 -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: capture REQ_ERR = PSLVERR. Capture REQ_RDATA = PRDATA for reads and 0 for writes. -> DONE.
  - PREADY=0: increment wait counter. When the counter reaches TIMEOUT (TIMEOUT≠0), REQ_ERR=1, REQ_RDATA=0 -> DONE.
- DONE: PSEL=PENABLE=0; REQ_DONE[winner]=1 for exactly this cycle -> IDLE. No arbitration in DONE.
- Requester contract: drop REQ_VALID in the cycle after observing REQ_DONE, or keep it high to issue a new request, which re-arbitrates in IDLE.
- PSLVERR is ignored outside ACCESS&PREADY.

## Timing
- All outputs are registered; reset value of every output is 0. State resets to IDLE, wait counter to 0, last_grant to 1.
- Zero-wait transfer, with REQ_VALID seen in IDLE at cycle 0:
  - cycle 1: PSEL
  - cycle 2: PENABLE with PREADY
  - cycle 3: REQ_DONE
  - cycle 4: IDLE, next grant possible
- Minimum 4 cycles per transfer; each PREADY-low cycle adds 1.
- Wait counter: width $clog2(TIMEOUT+1); cleared on entry to SETUP.
  - Abort occurs when TIMEOUT consecutive PREADY-low ACCESS cycles have elapsed, i.e. ACCESS lasts TIMEOUT cycles.
  - If PREADY rises in the same cycle the limit is hit, PREADY wins (normal completion).
- Simultaneous requests: alternate strictly while both are held. A single persistent requester is served back-to-back with no idle penalty beyond the IDLE cycle.
- Reset mid-transfer: PSEL/PENABLE/REQ_DONE drop immediately (asynchronously). The in-flight transfer is lost and no DONE is issued.

## Structure
- Package apb_arb_pkg:
  - state enum typedef (IDLE, SETUP, ACCESS, DONE)
  - localparam NUM_REQ = 2
  - APB PROT field constants
- Sub-module apb_rr_pick: combinational two-way round-robin pick (valid[1:0], last_grant -> grant_idx, any_valid). The FSM, capture registers and timeout counter stay in apb_master_arbiter.

## Test plan
- Req0 write, ADDR=0x1000_0010, WDATA=0xDEAD_BEEF, STRB=0xF, PREADY tied 1 -> PSEL cycle 1, PENABLE cycle 2, REQ_DONE=2'b01 cycle 3, REQ_ERR=0.
- Req1 read ADDR=0x20, PREADY low 3 cycles, then high with PRDATA=0x1234_5678 -> ACCESS lasts 4 cycles, REQ_RDATA=0x1234_5678, PSTRB=0 throughout.
- Both valid from reset, held for 4 transfers -> grant order 0,1,0,1; each DONE goes to the matching bit.
- TIMEOUT=16, PREADY stuck low -> ACCESS lasts exactly 16 cycles, DONE with REQ_ERR=1, REQ_RDATA=0; bus then idle.
- Write with PSLVERR=1 at PREADY -> REQ_ERR=1. Assert PRESETn low during ACCESS -> all outputs 0 immediately, no REQ_DONE; next tie after reset is granted to requester 0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and constants for the two-requester APB master arbiter
package apb_arb_pkg;
  localparam int NUM_REQ = 2;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;
  localparam logic [2:0] PROT_PRIV   = 3'b001;
  localparam logic [2:0] PROT_NONSEC = 3'b010;
  localparam logic [2:0] PROT_INSTR  = 3'b100;
  function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester command bundle plus APB master bus
interface apb_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import apb_arb_pkg::*;
  logic [NUM_REQ-1:0]          REQ_VALID;
  logic [NUM_REQ-1:0]          REQ_WRITE;
  logic [NUM_REQ*ADDR_W-1:0]   REQ_ADDR;
  logic [NUM_REQ*DATA_W-1:0]   REQ_WDATA;
  logic [NUM_REQ*DATA_W/8-1:0] REQ_STRB;
  logic [NUM_REQ*3-1:0]        REQ_PROT;
  logic [NUM_REQ-1:0]          REQ_DONE;
  logic [DATA_W-1:0]           REQ_RDATA;
  logic                        REQ_ERR;
  logic                        PSEL;
  logic                        PENABLE;
  logic                        PWRITE;
  logic [ADDR_W-1:0]           PADDR;
  logic [DATA_W-1:0]           PWDATA;
  logic [DATA_W/8-1:0]         PSTRB;
  logic [2:0]                  PROT;
  logic [DATA_W-1:0]           PRDATA;
  logic                        PREADY;
  logic                        PSLVERR;
  modport master (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_STRB, REQ_PROT,
    input  PRDATA, PREADY, PSLVERR,
    output REQ_DONE, REQ_RDATA, REQ_ERR,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PROT
  );
  modport slave (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_STRB, REQ_PROT,
    output PRDATA, PREADY, PSLVERR,
    input  REQ_DONE, REQ_RDATA, REQ_ERR,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PROT
  );
endinterface

// File: rtl/apb_rr_pick.sv
// apb_rr_pick: two-way round-robin pick favouring the requester not granted last
module apb_rr_pick
  import apb_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               last_grant_i,
  output logic               grant_idx_o,
  output logic               any_valid_o
);
  assign any_valid_o = |valid_i;
  assign grant_idx_o = &valid_i ? ~last_grant_i : valid_i[1];
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin sequencer of two requesters onto one APB master port,
// with a PREADY-low timeout that aborts transfers to a hung slave.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic                  PCLK,
  input logic                  PRESETn,
  apb_master_arbiter_if.master bus
);
  localparam int SW = DATA_W / 8;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_SETUP  = ST_SETUP;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;
  localparam logic [1:0] S_DONE   = ST_DONE;
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [SW-1:0]      pstrb_q, pstrb_d;
  logic [2:0]         prot_q, prot_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               gnt, any_valid, timeout_hit;
  logic               req_write;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic [SW-1:0]      req_strb;
  logic [2:0]         req_prot;

  apb_rr_pick u_pick (
    .valid_i      (bus.REQ_VALID),
    .last_grant_i (last_q),
    .grant_idx_o  (gnt),
    .any_valid_o  (any_valid)
  );

  assign req_write = bus.REQ_WRITE[gnt];
  assign req_addr  = gnt ? bus.REQ_ADDR[2*ADDR_W-1:ADDR_W]  : bus.REQ_ADDR[ADDR_W-1:0];
  assign req_wdata = gnt ? bus.REQ_WDATA[2*DATA_W-1:DATA_W] : bus.REQ_WDATA[DATA_W-1:0];
  assign req_strb  = gnt ? bus.REQ_STRB[2*SW-1:SW]          : bus.REQ_STRB[SW-1:0];
  assign req_prot  = gnt ? bus.REQ_PROT[5:3]                : bus.REQ_PROT[2:0];
  // The limit is hit on the TIMEOUT-th PREADY-low ACCESS cycle; PREADY takes priority.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    prot_d   = prot_q;
    rdata_d  = '0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: if (any_valid) begin
        state_d  = S_SETUP;
        cnt_d    = '0;
        last_d   = gnt;
        pwrite_d = req_write;
        paddr_d  = req_addr;
        pwdata_d = req_write ? req_wdata : '0;
        pstrb_d  = req_write ? req_strb : '0;
        prot_d   = req_prot;
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: if (bus.PREADY) begin
        state_d = S_DONE;
        err_d   = bus.PSLVERR;
        rdata_d = pwrite_q ? '0 : bus.PRDATA;
      end else if (timeout_hit) begin
        state_d = S_DONE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
  assign penable_d = state_d == S_ACCESS;
  assign done_d    = (state_d == S_DONE) ? req_onehot(last_d) : '0;

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      prot_q    <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      prot_q    <= prot_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end

  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.PROT      = prot_q;
  assign bus.REQ_DONE  = done_q;
  assign bus.REQ_RDATA = rdata_q;
  assign bus.REQ_ERR   = err_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed and randomized transfers checked against a transaction-level model
module tb_apb_master_arbiter;
  localparam int TO = 16;
  logic PCLK = 1'b0;
  logic PRESETn;
  int n_cmp = 0;
  int n_bad = 0;
  int last_g = 1;
  logic [1:0] rv, rw;
  logic [31:0] ra [2];
  logic [31:0] rd [2];
  logic [3:0]  rs [2];
  logic [2:0]  rp [2];

  apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_req();
    bus.REQ_VALID = rv;
    bus.REQ_WRITE = rw;
    bus.REQ_ADDR  = {ra[1], ra[0]};
    bus.REQ_WDATA = {rd[1], rd[0]};
    bus.REQ_STRB  = {rs[1], rs[0]};
    bus.REQ_PROT  = {rp[1], rp[0]};
  endtask

  task automatic new_req(input int i);
    rv[i] = 1'b1;
    rw[i] = 1'($urandom_range(0, 1));
    ra[i] = $urandom;
    rd[i] = $urandom;
    rs[i] = 4'($urandom);
    rp[i] = 3'($urandom);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_psel"}, 64'(bus.PSEL), 0);
    check({tag, "_pen"}, 64'(bus.PENABLE), 0);
    check({tag, "_pwrite"}, 64'(bus.PWRITE), 0);
    check({tag, "_paddr"}, 64'(bus.PADDR), 0);
    check({tag, "_pwdata"}, 64'(bus.PWDATA), 0);
    check({tag, "_pstrb"}, 64'(bus.PSTRB), 0);
    check({tag, "_prot"}, 64'(bus.PROT), 0);
    check({tag, "_done"}, 64'(bus.REQ_DONE), 0);
    check({tag, "_err"}, 64'(bus.REQ_ERR), 0);
    check({tag, "_rdata"}, 64'(bus.REQ_RDATA), 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge PCLK);
      check("idle_psel", 64'(bus.PSEL), 0);
      check("idle_done", 64'(bus.REQ_DONE), 0);
    end
  endtask

  // lat: cycles from now until PSEL; w: PREADY-low cycles before PREADY; after: 0 drop, 1 reissue, 2 random
  task automatic xfer(input int lat, input int w, input bit slverr, input logic [31:0] prd, input int after);
    int win, n, len;
    logic exp_w;
    logic [31:0] exp_a;
    logic [3:0] exp_s;
    win = (rv == 2'b11) ? 1 - last_g : (rv[1] ? 1 : 0);
    last_g = win;
    exp_w = rw[win];
    exp_a = ra[win];
    exp_s = exp_w ? rs[win] : 4'h0;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!bus.PSEL && n < 8);
    check("psel_lat", 64'(n), 64'(lat));
    check("setup_pen", 64'(bus.PENABLE), 0);
    check("paddr", 64'(bus.PADDR), 64'(exp_a));
    check("pwrite", 64'(bus.PWRITE), 64'(exp_w));
    check("pwdata", 64'(bus.PWDATA), exp_w ? 64'(rd[win]) : 64'h0);
    check("pstrb", 64'(bus.PSTRB), 64'(exp_s));
    check("prot", 64'(bus.PROT), 64'(rp[win]));
    bus.PREADY  = 1'($urandom_range(0, 1));
    bus.PSLVERR = 1'($urandom_range(0, 1));
    bus.PRDATA  = $urandom;
    if (after == 2 && !rv[1-win] && $urandom_range(0, 2) == 0) begin
      new_req(1 - win);
      drive_req();
    end
    len = (w < TO) ? w + 1 : TO;
    for (int k = 0; k < len; k++) begin
      @(negedge PCLK);
      check("access", 64'({bus.PSEL, bus.PENABLE}), 64'b11);
      check("acc_paddr", 64'(bus.PADDR), 64'(exp_a));
      check("acc_pstrb", 64'(bus.PSTRB), 64'(exp_s));
      check("acc_done", 64'(bus.REQ_DONE), 0);
      bus.PREADY  = (k == w);
      bus.PSLVERR = (k == w) ? slverr : 1'($urandom_range(0, 1));
      bus.PRDATA  = (k == w) ? prd : $urandom;
    end
    @(negedge PCLK);
    check("done", 64'(bus.REQ_DONE), win ? 64'b10 : 64'b01);
    check("done_bus", 64'({bus.PSEL, bus.PENABLE}), 0);
    check("err", 64'(bus.REQ_ERR), (w < TO) ? 64'(slverr) : 64'h1);
    check("rdata", 64'(bus.REQ_RDATA), (w < TO && !exp_w) ? 64'(prd) : 64'h0);
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    rv[win] = 1'b0;
    if (after == 1 || (after == 2 && $urandom_range(0, 1) == 1)) new_req(win);
    if (after == 2 && !rv[1-win] && $urandom_range(0, 3) == 0) new_req(1 - win);
    drive_req();
  endtask

  initial begin
    int lat, w;
    PRESETn = 1'b0;
    rv = '0;
    rw = '0;
    for (int i = 0; i < 2; i++) begin
      ra[i] = '0;
      rd[i] = '0;
      rs[i] = '0;
      rp[i] = '0;
    end
    drive_req();
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = '0;
    repeat (3) @(negedge PCLK);
    chk_zero("reset");
    PRESETn = 1'b1;
    @(negedge PCLK);
    rw[0] = 1'b1; ra[0] = 32'h1000_0010; rd[0] = 32'hDEAD_BEEF; rs[0] = 4'hF; rp[0] = 3'b010;
    rv = 2'b01;
    drive_req();
    xfer(1, 0, 1'b0, 32'h0, 0);
    idle_cycles(1);
    rw[1] = 1'b0; ra[1] = 32'h20; rd[1] = 32'hFFFF_FFFF; rs[1] = 4'hA; rp[1] = 3'b001;
    rv = 2'b10;
    drive_req();
    xfer(1, 3, 1'b0, 32'h1234_5678, 0);
    idle_cycles(1);
    rw[0] = 1'b0; ra[0] = 32'h40;
    rv = 2'b01;
    drive_req();
    xfer(1, 40, 1'b0, 32'hCAFE_F00D, 0);
    idle_cycles(3);
    rw[1] = 1'b1; ra[1] = 32'h80; rd[1] = 32'h5555_AAAA; rs[1] = 4'h3;
    rv = 2'b10;
    drive_req();
    xfer(1, 1, 1'b1, 32'h0, 0);
    idle_cycles(1);
    rw[0] = 1'b1; ra[0] = 32'h100; rd[0] = 32'h0BAD_0BAD; rs[0] = 4'h1;
    rv = 2'b01;
    drive_req();
    lat = 0;
    do begin
      @(negedge PCLK);
      lat++;
    end while (!bus.PSEL && lat < 8);
    check("rst_lat", 64'(lat), 1);
    @(negedge PCLK);
    check("rst_access", 64'({bus.PSEL, bus.PENABLE}), 64'b11);
    #2 PRESETn = 1'b0;
    #1 chk_zero("rst_mid");
    rv = '0;
    drive_req();
    repeat (2) begin
      @(negedge PCLK);
      check("rst_hold_done", 64'(bus.REQ_DONE), 0);
    end
    PRESETn = 1'b1;
    last_g = 1;
    @(negedge PCLK);
    new_req(0);
    new_req(1);
    drive_req();
    lat = 1;
    for (int t = 0; t < 4; t++) begin
      xfer(lat, $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom, 1);
      lat = 2;
    end
    for (int t = 0; t < 150; t++) begin
      if (rv == 2'b00) begin
        idle_cycles($urandom_range(1, 3));
        new_req($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) new_req($urandom_range(0, 1));
        drive_req();
        lat = 1;
      end
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
      xfer(lat, w, 1'($urandom_range(0, 1)), $urandom, 2);
      lat = 2;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
